// File: rtl/grf_mwnr_if.sv
// Write/read bus of the general register file: two byte-enabled write ports,
// NRD packed read ports and the sweep-busy flag.
interface grf_mwnr_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NRD    = 2
);
  localparam int NB = DATA_W / 8;

  logic                  i_clk_en;
  logic                  i_cs_b;
  logic [ADDR_W-1:0]     i_waddr_a;
  logic [NB-1:0]         i_wen_a;
  logic [DATA_W-1:0]     i_din_a;
  logic [ADDR_W-1:0]     i_waddr_b;
  logic [NB-1:0]         i_wen_b;
  logic [DATA_W-1:0]     i_din_b;
  logic [NRD*ADDR_W-1:0] i_raddr;
  logic [NRD*DATA_W-1:0] o_dout;
  logic                  o_busy;

  modport master (
    output i_clk_en, i_cs_b,
    output i_waddr_a, i_wen_a, i_din_a,
    output i_waddr_b, i_wen_b, i_din_b,
    output i_raddr,
    input  o_dout, o_busy
  );

  modport slave (
    input  i_clk_en, i_cs_b,
    input  i_waddr_a, i_wen_a, i_din_a,
    input  i_waddr_b, i_wen_b, i_din_b,
    input  i_raddr,
    output o_dout, o_busy
  );
endinterface

// File: rtl/grf_mwnr.sv
// Parametrised register file: two byte-enabled write ports, NRD asynchronous
// read ports with write-through bypass, optional zero register, clear sweep.
module grf_mwnr #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int NRD     = 2,
  parameter int R0_ZERO = 0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  grf_mwnr_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ccnt, ccnt_nxt;
  logic              clr_we;
  logic              busy;

  logic [DATA_W-1:0] rf [DEPTH];

  logic              wv_a, wv_b, same;
  logic [DATA_W-1:0] word_a, word_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] din,
                                               input logic [NB-1:0]     wen);
    logic [DATA_W-1:0] res;
    res = old;
    for (int j = 0; j < NB; j++)
      if (wen[j]) res[8*j +: 8] = din[8*j +: 8];
    return res;
  endfunction

  // Control: state and sweep counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= CLEAR;
      ccnt  <= '0;
    end else begin
      state <= state_nxt;
      ccnt  <= ccnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ccnt_nxt  = ccnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        if (bus.i_clk_en) begin
          clr_we   = !i_rst;
          ccnt_nxt = ccnt + 1'b1;
          if (ccnt == LAST) begin
            state_nxt = RUN;
            ccnt_nxt  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy       = (state == CLEAR);
  assign bus.o_busy = busy;

  // Write qualification; a write discarded by reset must not bypass either
  assign wv_a = (state == RUN) && bus.i_clk_en && !bus.i_cs_b && !i_rst &&
                (|bus.i_wen_a) && in_range(bus.i_waddr_a) && !is_zero_reg(bus.i_waddr_a);
  assign wv_b = (state == RUN) && bus.i_clk_en && !bus.i_cs_b && !i_rst &&
                (|bus.i_wen_b) && in_range(bus.i_waddr_b) && !is_zero_reg(bus.i_waddr_b);
  assign same = wv_a && wv_b && (bus.i_waddr_a == bus.i_waddr_b);

  // On a collision B is merged on top of A's word so B wins per byte
  always_comb begin
    word_a = merge(in_range(bus.i_waddr_a) ? rf[bus.i_waddr_a] : '0,
                   bus.i_din_a, bus.i_wen_a);
    word_b = merge(same ? word_a :
                   (in_range(bus.i_waddr_b) ? rf[bus.i_waddr_b] : '0),
                   bus.i_din_b, bus.i_wen_b);
  end

  // Storage: sweep clear or merged port writes
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      rf[ccnt] <= '0;
    end else begin
      if (wv_a && !same) rf[bus.i_waddr_a] <= word_a;
      if (wv_b)          rf[bus.i_waddr_b] <= word_b;
    end
  end

  // Read ports: zero/out-of-range, then bypass, then storage
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rword;

    assign ra = bus.i_raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rword = '0;
      if (busy || !in_range(ra) || is_zero_reg(ra))
        rword = '0;
      else if (wv_b && (bus.i_waddr_b == ra))
        rword = word_b;
      else if (wv_a && (bus.i_waddr_a == ra))
        rword = word_a;
      else
        rword = rf[ra];
    end

    assign bus.o_dout[k*DATA_W +: DATA_W] = rword;
  end
endmodule

// File: doc/grf_mwnr.md
# grf_mwnr

Parametrised general register file: the successor to the fixed 16x32, one-write/two-read file in the processor datapath. It provides two byte-enabled write ports, a configurable number of asynchronous read ports with write-through bypass, an optional hard-wired zero register and a self-clearing reset sweep. It sits between decode (read addresses) and writeback (ALU and load-return write ports).

## Interface

Parameters:
- DATA_W, 32: word width; must be a multiple of 8; NB = DATA_W/8 byte lanes.
- DEPTH, 16: number of entries, 2..256; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- NRD, 2: number of read ports, 1..4.
- R0_ZERO, 0: 1 = entry 0 reads as zero and ignores writes.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_clk_en  in  1  clock enable; gates writes and the clear sweep.
- i_cs_b  in  1  active-low chip select for both write ports.
- i_waddr_a  in  ADDR_W  write port A address.
- i_wen_a  in  NB  port A byte enables.
- i_din_a  in  DATA_W  port A data.
- i_waddr_b  in  ADDR_W  write port B address.
- i_wen_b  in  NB  port B byte enables.
- i_din_b  in  DATA_W  port B data.
- i_raddr  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- o_dout  out  NRD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
- o_busy  out  1  high while the clear sweep runs.

## Operation

- States are CLEAR and RUN, plus a clear counter ccnt of ADDR_W bits.
- Reset: i_rst sampled high sets state to CLEAR, ccnt to 0 and o_busy to 1. It has priority over everything else. i_rst asserted mid-sweep restarts the sweep at entry 0. i_rst asserted in RUN discards any write in that cycle.
- CLEAR: on each edge with i_clk_en=1, write 0 to entry ccnt and increment ccnt. The edge that writes entry DEPTH-1 moves the state to RUN and drops o_busy. With i_clk_en=0 the sweep holds.
- In CLEAR, both write ports are ignored and every o_dout lane is 0.
- Port write valid: wv_x = state==RUN & i_clk_en & !i_cs_b & |i_wen_x & addr_x<DEPTH & !(R0_ZERO & addr_x==0).
- Merge per byte j, starting from rf[addr]: for A, byte j = i_wen_a[j] ? i_din_a byte : old byte. For B, the same rule applied to B's target address.
- Same address, both valid: B overrides A per byte. A byte enabled only in A takes A's data; a byte enabled in neither keeps the old value. Exactly one merged word is committed.
- Different addresses: both words are committed on the same edge.
- Read port k returns the following, in priority order:
  - 0 if busy, raddr>=DEPTH, or (R0_ZERO and raddr==0);
  - else the merged word of a valid write hitting raddr (the combined A/B word if both hit);
  - else rf[raddr].
- Bypass is purely combinational and is only applied for a write that will commit on the next edge.
- Out-of-range write addresses (DEPTH not a power of two) are dropped silently.

## Timing

- Reads are asynchronous, with zero-cycle latency from i_raddr, or from the write inputs via bypass, to o_dout.
- Writes take effect at the rising edge. Storage holds the new value from the next cycle on.
- Sweep length is exactly DEPTH enabled cycles after the cycle in which i_rst is sampled high. o_busy is 1 for those cycles and 0 from the following cycle.
- Values after reset: o_busy=1, every o_dout lane=0; after the sweep, all entries are 0.
- No handshake on the write ports. Software and the pipeline must hold writes off while o_busy=1; writes presented during busy are lost.

## Test plan

- Reset sweep: pulse i_rst for 1 cycle with DEPTH=16 and i_clk_en=1 -> o_busy high for exactly 16 cycles. All reads return 0, and a write of 0xDEADBEEF to R3 during busy is lost (R3 reads 0 afterwards). Repeat with i_clk_en toggling every other cycle -> busy lasts 32 cycles.
- Byte merge: write R5=0x11223344 with wen_a=0xF. Next, write wen_a=0x2 din_a=0xAAAAAAAA -> R5 reads 0x1122AA44.
- Dual-port collision on R7 (old 0x00000000): wen_a=0x3 din_a=0x0000BBCC and wen_b=0x6 din_b=0x00DDEE00 in one cycle -> R7 = 0x00DDEECC, and all read ports addressing R7 show 0x00DDEECC in that same cycle.
- Bypass gating: write R2=0x5A5A5A5A while raddr0=2 and raddr1=3 -> dout0=0x5A5A5A5A in the write cycle and dout1=old R3. Repeat with i_cs_b=1 or i_clk_en=0 -> dout0 = old R2 and storage unchanged.
- R0_ZERO=1 and DEPTH=12: write 0xFFFFFFFF to R0 and to address 13 -> reads of R0 and of address 13 return 0, and R0 stays 0 in storage.
- Reset mid-sweep and mid-write: assert i_rst at sweep cycle 9 -> the sweep restarts and lasts 16 more cycles. Assert i_rst in RUN concurrent with a write to R4=0x12345678 -> R4 reads 0 after the sweep.
